// File: rtl/bc_context_ctrl.sv
// Context save/restore sequencer: moves r1..r31, HI and LO between the register
// file and a 33-word memory frame using a request/ready memory handshake.
module bc_context_ctrl #(
    parameter int ADDR_W = 32,
    parameter int STRIDE = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              op,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic [4:0]        rf_rs,
    input  logic [31:0]       rf_read1,
    input  logic [31:0]       rf_hi,
    input  logic [31:0]       rf_lo,
    output logic [4:0]        rf_rd,
    output logic [31:0]       rf_write_data,
    output logic              rf_reg_write,
    output logic [2:0]        rf_loc_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready
);
    typedef enum logic [2:0] {IDLE, S_ADDR, S_READ, S_MEM, R_MEM, R_WB, DONE} state_t;

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(STRIDE);
    localparam logic [5:0]        LAST = 6'd32;

    state_t      state;
    logic [5:0]  k;
    logic [31:0] save_word;
    logic [4:0]  next_rs;

    always_comb begin
        save_word = rf_read1;
        if (k == 6'd31)
            save_word = rf_hi;
        else if (k == LAST)
            save_word = rf_lo;
    end

    // Read index for word k+1; the HI/LO slots (31, 32) do not use the read port.
    assign next_rs = (k >= 6'd30) ? 5'd0 : 5'(k) + 5'd2;

    // mem_addr doubles as the frame pointer and advances by STRIDE per word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            k             <= 6'd0;
            busy          <= 1'b0;
            done          <= 1'b0;
            rf_rs         <= 5'd0;
            rf_rd         <= 5'd0;
            rf_write_data <= 32'd0;
            rf_reg_write  <= 1'b0;
            rf_loc_write  <= 3'b000;
            mem_addr      <= '0;
            mem_wdata     <= 32'd0;
            mem_we        <= 1'b0;
            mem_re        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        k        <= 6'd0;
                        busy     <= 1'b1;
                        mem_addr <= base_addr;
                        if (op) begin
                            mem_re <= 1'b1;
                            state  <= R_MEM;
                        end else begin
                            rf_rs <= 5'd1;
                            state <= S_ADDR;
                        end
                    end
                end
                S_ADDR: state <= S_READ;
                S_READ: begin
                    mem_wdata <= save_word;
                    mem_we    <= 1'b1;
                    state     <= S_MEM;
                end
                S_MEM: begin
                    if (mem_ready) begin
                        mem_we <= 1'b0;
                        if (k == LAST) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            k        <= k + 6'd1;
                            mem_addr <= mem_addr + STEP;
                            rf_rs    <= next_rs;
                            state    <= S_ADDR;
                        end
                    end
                end
                R_MEM: begin
                    if (mem_ready) begin
                        mem_re        <= 1'b0;
                        rf_reg_write  <= 1'b1;
                        rf_write_data <= mem_rdata;
                        if (k <= 6'd30) begin
                            rf_loc_write <= 3'b000;
                            rf_rd        <= 5'(k) + 5'd1;
                        end else if (k == 6'd31) begin
                            rf_loc_write <= 3'b011;
                        end else begin
                            rf_loc_write <= 3'b100;
                        end
                        state <= R_WB;
                    end
                end
                R_WB: begin
                    rf_reg_write  <= 1'b0;
                    rf_rd         <= 5'd0;
                    rf_loc_write  <= 3'b000;
                    rf_write_data <= 32'd0;
                    if (k == LAST) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        k        <= k + 6'd1;
                        mem_addr <= mem_addr + STEP;
                        mem_re   <= 1'b1;
                        state    <= R_MEM;
                    end
                end
                DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    rf_rs     <= 5'd0;
                    mem_addr  <= '0;
                    mem_wdata <= 32'd0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
